setup: RTL and testbench

- Configuration-mode controller of the digital door lock (fechadura).
- Entered via `setup_on`; consumes keypad digits; drives the 6-digit BCD display with the field being edited.
- Holds the lock configuration record (`setupPac_t`) and publishes it on `data_setup_new`, with `data_setup_ok` flagging a completed save.
- This release edits one field, `bip_status` (beep on/off). All other configuration fields pass through unchanged.

---
 rtl/setup.sv | 177 +++++++++++++++++
 tb/tb_setup.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/setup.sv
// -----------------------------------------------------------------------------
// setup_pkg / setup
// Configuration-mode controller of the digital door lock.
//
// setup_pkg : keypad, display and configuration record types shared by the
//             lock blocks.
// setup     : entered on setup_on, edits the beep enable (bip_status) from
//             keypad digits, shows the field on the 6-digit BCD display and
//             publishes the committed configuration.
//
// Ports (setup):
//   clk            in   system clock, rising edge
//   rst            in   synchronous reset, active low
//   setup_on       in   request to enter setup mode (level)
//   digitos_value  in   keypad data, key code in digits[0]
//   digitos_valid  in   one-cycle strobe qualifying digitos_value
//   display_en     out  setup owns the display
//   bcd_pac        out  display digits BCD5..BCD0
//   data_setup_new out  committed configuration record
//   data_setup_ok  out  a save completed since the last setup entry
// -----------------------------------------------------------------------------
package setup_pkg;
   localparam int SENHA_DIGITS = 8;

   typedef struct packed {
      logic [SENHA_DIGITS-1:0][3:0] digits;   // digits[0] at bits [3:0]
   } senhaPac_t;

   typedef struct packed {
      logic [3:0] bcd5;
      logic [3:0] bcd4;
      logic [3:0] bcd3;
      logic [3:0] bcd2;
      logic [3:0] bcd1;
      logic [3:0] bcd0;
   } bcdPac_t;

   typedef struct packed {
      logic      bip_status;
      logic [7:0] bip_time;
      logic [7:0] tranca_aut_time;
      senhaPac_t  senha_master;
      senhaPac_t  senha_1;
      senhaPac_t  senha_2;
      senhaPac_t  senha_3;
      senhaPac_t  senha_4;
   } setupPac_t;
endpackage

module setup
   import setup_pkg::*;
#(
   parameter logic [3:0] BLANK_DIGIT  = 4'hF,
   parameter logic [3:0] BIP_FIELD_ID = 4'd1
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      setup_on,
   input  senhaPac_t digitos_value,
   input  logic      digitos_valid,
   output logic      display_en,
   output bcdPac_t   bcd_pac,
   output setupPac_t data_setup_new,
   output logic      data_setup_ok
);

   typedef enum logic [1:0] {IDLE, EDIT_BIP, CONFIRM} state_t;

   localparam logic [3:0] KEY_NEXT = 4'hA;
   localparam logic [3:0] KEY_SAVE = 4'hB;

   state_t    state_q, state_d;
   logic      cand_q, cand_d;
   setupPac_t cfg_q, cfg_d;
   logic      ok_q, ok_d;
   logic [3:0] key;

   // Factory configuration: master code 1-2-3-4, user codes disabled.
   function automatic setupPac_t cfg_default();
      setupPac_t c;
      c.bip_status      = 1'b1;
      c.bip_time        = 8'd5;
      c.tranca_aut_time = 8'd5;
      for (int i = 0; i < SENHA_DIGITS; i++) begin
         c.senha_master.digits[i] = 4'hF;
         c.senha_1.digits[i]      = 4'hF;
         c.senha_2.digits[i]      = 4'hF;
         c.senha_3.digits[i]      = 4'hF;
         c.senha_4.digits[i]      = 4'hF;
      end
      c.senha_master.digits[0] = 4'd1;
      c.senha_master.digits[1] = 4'd2;
      c.senha_master.digits[2] = 4'd3;
      c.senha_master.digits[3] = 4'd4;
      return c;
   endfunction

   assign key = digitos_value.digits[0];

   // Only the low digit carries a key code; the rest of the bus is unused here.
   logic unused_key_hi;
   assign unused_key_hi = ^digitos_value.digits[SENHA_DIGITS-1:1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cand_q  <= 1'b0;
         cfg_q   <= cfg_default();
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cfg_q   <= cfg_d;
         ok_q    <= ok_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cfg_d   = cfg_q;
      ok_d    = ok_q;
      case (state_q)
         IDLE: begin
            // Keys on the entry edge are dropped: IDLE never looks at them.
            if (setup_on) begin
               cand_d  = cfg_q.bip_status;
               ok_d    = 1'b0;
               state_d = EDIT_BIP;
            end
         end
         EDIT_BIP: begin
            if (digitos_valid) begin
               if (key == 4'h0 || key == 4'h1) begin
                  cand_d = key[0];
               end else if (key == KEY_NEXT) begin
                  state_d = CONFIRM;
               end else if (key == KEY_SAVE) begin
                  cfg_d.bip_status = cand_q;
                  ok_d             = 1'b1;
                  state_d          = IDLE;
               end
            end
         end
         CONFIRM: begin
            if (digitos_valid) begin
               if (key == KEY_SAVE) begin
                  cfg_d.bip_status = cand_q;
                  ok_d             = 1'b1;
                  state_d          = IDLE;
               end else if (key == KEY_NEXT) begin
                  state_d = EDIT_BIP;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      display_en   = (state_q != IDLE);
      bcd_pac.bcd5 = BLANK_DIGIT;
      bcd_pac.bcd4 = BLANK_DIGIT;
      bcd_pac.bcd3 = BLANK_DIGIT;
      bcd_pac.bcd2 = BLANK_DIGIT;
      bcd_pac.bcd1 = BLANK_DIGIT;
      bcd_pac.bcd0 = BLANK_DIGIT;
      if (state_q != IDLE) begin
         bcd_pac.bcd5 = BIP_FIELD_ID;
         bcd_pac.bcd0 = {3'b000, cand_q};
      end
   end

   assign data_setup_new = cfg_q;
   assign data_setup_ok  = ok_q;

endmodule

// File: tb/tb_setup.sv
// -----------------------------------------------------------------------------
// tb_setup
// Directed bench for the setup controller. Stimulus pushes the expected output
// snapshot for a given cycle into a queue; a monitor on the falling edge pops
// and compares whatever is due.
// -----------------------------------------------------------------------------
module tb_setup;
   import setup_pkg::*;

   logic      clk = 1'b0;
   logic      rst;
   logic      setup_on;
   senhaPac_t digitos_value;
   logic      digitos_valid;
   logic      display_en;
   bcdPac_t   bcd_pac;
   setupPac_t data_setup_new;
   logic      data_setup_ok;

   setup dut (
      .clk            (clk),
      .rst            (rst),
      .setup_on       (setup_on),
      .digitos_value  (digitos_value),
      .digitos_valid  (digitos_valid),
      .display_en     (display_en),
      .bcd_pac        (bcd_pac),
      .data_setup_new (data_setup_new),
      .data_setup_ok  (data_setup_ok)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] cyc;
      logic        disp;
      bcdPac_t     bcd;
      setupPac_t   cfg;
      logic        ok;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   logic [31:0] cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Hand-written expected configurations.
   setupPac_t CFG_DEF, CFG_B0, CFG_B1;
   initial begin
      CFG_DEF.bip_status      = 1'b1;
      CFG_DEF.bip_time        = 8'd5;
      CFG_DEF.tranca_aut_time = 8'd5;
      CFG_DEF.senha_master    = 32'hFFFF_4321;
      CFG_DEF.senha_1         = 32'hFFFF_FFFF;
      CFG_DEF.senha_2         = 32'hFFFF_FFFF;
      CFG_DEF.senha_3         = 32'hFFFF_FFFF;
      CFG_DEF.senha_4         = 32'hFFFF_FFFF;
      CFG_B0 = CFG_DEF;
      CFG_B0.bip_status = 1'b0;
      CFG_B1 = CFG_DEF;
   end

   localparam logic [23:0] BCD_BLANK = 24'hFFFFFF;
   localparam logic [23:0] BCD_BIP0  = 24'h1FFFF0;
   localparam logic [23:0] BCD_BIP1  = 24'h1FFFF1;

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         exp_t  e;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_tests++;
         if (display_en !== e.disp || bcd_pac !== e.bcd ||
             data_setup_new !== e.cfg || data_setup_ok !== e.ok) begin
            n_fail++;
            $display("FAIL %s: got disp=%b bcd=%h cfg=%h ok=%b, want disp=%b bcd=%h cfg=%h ok=%b",
                     nm, display_en, bcd_pac, data_setup_new, data_setup_ok,
                     e.disp, e.bcd, e.cfg, e.ok);
         end
      end
   end

   // One clock of stimulus; returns #1 after the edge that sampled it.
   task automatic step(input logic s_on, input logic v, input logic [3:0] k,
                       input logic r = 1'b1);
      rst                     = r;
      setup_on                = s_on;
      digitos_valid           = v;
      digitos_value           = 32'h5555_5550;   // junk in upper digits
      digitos_value.digits[0] = k;
      @(posedge clk);
      #1;
      setup_on      = 1'b0;
      digitos_valid = 1'b0;
      rst           = 1'b1;
   endtask

   task automatic expect_now(input string nm, input logic d, input logic [23:0] b,
                             input setupPac_t c, input logic o);
      exp_t e;
      e.cyc  = cyc;
      e.disp = d;
      e.bcd  = b;
      e.cfg  = c;
      e.ok   = o;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   initial begin
      rst = 1'b0; setup_on = 1'b0; digitos_valid = 1'b0; digitos_value = '0;
      step(0, 0, 4'h0, 0);
      step(0, 0, 4'h0, 0);
      expect_now("reset", 0, BCD_BLANK, CFG_DEF, 0);
      step(0, 0, 4'h0);
      expect_now("idle_after_reset", 0, BCD_BLANK, CFG_DEF, 0);

      // setup_on held two clocks: entry then ignored
      step(1, 0, 4'h0);
      expect_now("enter_1", 1, BCD_BIP1, CFG_DEF, 0);
      step(1, 0, 4'h0);
      expect_now("enter_2", 1, BCD_BIP1, CFG_DEF, 0);

      step(0, 1, 4'h1);
      expect_now("key1", 1, BCD_BIP1, CFG_DEF, 0);
      step(0, 1, 4'h0);
      expect_now("key0", 1, BCD_BIP0, CFG_DEF, 0);
      step(0, 0, 4'h1);
      expect_now("strobe_low", 1, BCD_BIP0, CFG_DEF, 0);
      for (int k = 2; k <= 9; k++) begin
         step(0, 1, 4'(k));
         expect_now($sformatf("ignored_%0d", k), 1, BCD_BIP0, CFG_DEF, 0);
      end
      step(0, 1, 4'hC);
      expect_now("ignored_C", 1, BCD_BIP0, CFG_DEF, 0);

      step(0, 1, 4'hA);
      expect_now("to_confirm", 1, BCD_BIP0, CFG_DEF, 0);
      step(0, 1, 4'hB);
      expect_now("commit_0", 0, BCD_BLANK, CFG_B0, 1);
      step(0, 0, 4'h0);
      expect_now("ok_held", 0, BCD_BLANK, CFG_B0, 1);
      step(0, 1, 4'h1);
      expect_now("idle_key_ignored", 0, BCD_BLANK, CFG_B0, 1);

      // re-enter: ok clears, committed value shown
      step(1, 0, 4'h0);
      expect_now("reenter", 1, BCD_BIP0, CFG_B0, 0);
      step(0, 1, 4'h1);
      expect_now("re_key1", 1, BCD_BIP1, CFG_B0, 0);
      step(1, 0, 4'h0);
      expect_now("setup_on_in_edit", 1, BCD_BIP1, CFG_B0, 0);
      step(0, 1, 4'hB);
      expect_now("commit_1", 0, BCD_BLANK, CFG_B1, 1);

      // CONFIRM ignores digits; A returns to edit
      step(1, 0, 4'h0);
      expect_now("enter_3", 1, BCD_BIP1, CFG_B1, 0);
      step(0, 1, 4'hA);
      step(0, 1, 4'h0);
      expect_now("confirm_ignores_0", 1, BCD_BIP1, CFG_B1, 0);
      step(0, 1, 4'hA);
      step(0, 1, 4'h0);
      expect_now("back_to_edit", 1, BCD_BIP0, CFG_B1, 0);
      step(0, 1, 4'hA);
      step(0, 1, 4'hB);
      expect_now("commit_confirm", 0, BCD_BLANK, CFG_B0, 1);

      // key on the entry edge is dropped
      step(1, 1, 4'h1);
      expect_now("entry_key_dropped", 1, BCD_BIP0, CFG_B0, 0);
      step(0, 1, 4'h1);
      expect_now("edit_key1", 1, BCD_BIP1, CFG_B0, 0);
      step(0, 1, 4'h0);
      // reset mid-edit restores defaults
      step(0, 0, 4'h0, 0);
      expect_now("reset_mid_edit", 0, BCD_BLANK, CFG_DEF, 0);
      step(0, 0, 4'h0);
      expect_now("idle_post_reset", 0, BCD_BLANK, CFG_DEF, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d pending, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
